whizgraphics: RTL and testbench

// Game Boy-style picture processor. Holds VRAM (384 tiles + two 32x32 maps), OAM (40 sprites) and LCD registers,
// all CPU-accessible over a byte bus. When LCD is enabled it renders 160x144 frames of background, window and

---
 rtl/whizgraphics.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_whizgraphics.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/whizgraphics.sv
// Game Boy-style picture processor: CPU-visible VRAM/OAM/LCD registers plus a line renderer
// producing one palette-mapped pixel per clock for a 160x144 frame.
module whizgraphics #(
  parameter bit DEBUG_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  data_out,
  output logic [7:0]  lcd_x,
  output logic [7:0]  lcd_y,
  output logic [1:0]  lcd_pix,
  output logic        lcd_we,
  output logic        render_complete
);

  typedef enum logic [1:0] {StIdle, StOamScan, StDraw, StVBlank} state_e;

  logic [7:0] r_vram [8192];
  logic [7:0] r_oam  [160];

  logic [7:0] r_lcdc, r_scy, r_scx, r_bgp, r_obp0, r_obp1, r_wy, r_wx;
  logic [7:0] r_scy_l, r_scx_l, r_wy_l, r_wx_l;
  state_e     r_state, w_state_d;
  logic [7:0] r_dot, w_dot_d, r_ly, w_ly_d;

  logic [7:0] r_spr_lo [10];
  logic [7:0] r_spr_hi [10];
  logic [7:0] r_spr_x  [10];
  logic [2:0] r_spr_flags [10];  // {behind_bg, xflip, obp1}
  logic [3:0] r_spr_cnt;

  logic [7:0] r_data_out, r_lcd_x, r_lcd_y;
  logic [1:0] r_lcd_pix;
  logic       r_lcd_we, r_render_complete;

  logic w_vram_sel, w_oam_sel, w_lcd_on, w_line_start;
  logic [7:0] w_rd_data;

  assign w_vram_sel = (addr[15:13] == 3'b100);
  assign w_oam_sel  = (addr[15:8] == 8'hFE) && (addr[7:0] < 8'hA0);
  // Disabling takes hold on the very edge that writes LCDC.
  assign w_lcd_on   = (we && addr == 16'hFF40) ? data_in[7] : r_lcdc[7];

  always_ff @(posedge clk) begin
    if (we && w_vram_sel) r_vram[addr[12:0]] <= data_in;
    if (we && w_oam_sel)  r_oam[addr[7:0]]   <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lcdc <= '0;
      r_scy  <= '0;
      r_scx  <= '0;
      r_bgp  <= 8'hE4;
      r_obp0 <= 8'hE4;
      r_obp1 <= 8'hE4;
      r_wy   <= '0;
      r_wx   <= '0;
    end else if (we) begin
      case (addr)
        16'hFF40: r_lcdc <= data_in;
        16'hFF42: r_scy  <= data_in;
        16'hFF43: r_scx  <= data_in;
        16'hFF47: r_bgp  <= data_in;
        16'hFF48: r_obp0 <= data_in;
        16'hFF49: r_obp1 <= data_in;
        16'hFF4A: r_wy   <= data_in;
        16'hFF4B: r_wx   <= data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = 8'hFF;
    if (w_vram_sel) begin
      w_rd_data = r_vram[addr[12:0]];
    end else if (w_oam_sel) begin
      w_rd_data = r_oam[addr[7:0]];
    end else begin
      case (addr)
        16'hFF40: w_rd_data = r_lcdc;
        16'hFF42: w_rd_data = r_scy;
        16'hFF43: w_rd_data = r_scx;
        16'hFF44: w_rd_data = r_ly;
        16'hFF47: w_rd_data = r_bgp;
        16'hFF48: w_rd_data = r_obp0;
        16'hFF49: w_rd_data = r_obp1;
        16'hFF4A: w_rd_data = r_wy;
        16'hFF4B: w_rd_data = r_wx;
        default:  w_rd_data = 8'hFF;
      endcase
    end
  end

  // Line timing: 40 scan dots then 160 draw dots; vblank lines are 200 dots.
  always_comb begin
    w_state_d = r_state;
    w_dot_d   = r_dot;
    w_ly_d    = r_ly;
    if (!w_lcd_on) begin
      w_state_d = StIdle;
      w_dot_d   = '0;
      w_ly_d    = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_d = StOamScan;
          w_dot_d   = '0;
          w_ly_d    = '0;
        end
        StOamScan: begin
          w_dot_d = r_dot + 8'd1;
          if (r_dot == 8'd39) w_state_d = StDraw;
        end
        StDraw: begin
          if (r_dot == 8'd199) begin
            w_dot_d = '0;
            w_ly_d  = r_ly + 8'd1;
            w_state_d = (r_ly == 8'd143) ? StVBlank : StOamScan;
          end else begin
            w_dot_d = r_dot + 8'd1;
          end
        end
        StVBlank: begin
          if (r_dot == 8'd199) begin
            w_dot_d = '0;
            if (r_ly == 8'd153) begin
              w_state_d = StOamScan;
              w_ly_d    = '0;
            end else begin
              w_ly_d = r_ly + 8'd1;
            end
          end else begin
            w_dot_d = r_dot + 8'd1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign w_line_start = (w_state_d == StOamScan) && (r_state != StOamScan);

  // OAM scan: entry r_dot checked this clock; sprite tile row fetched on selection.
  logic [7:0] w_scan_y, w_scan_x, w_scan_tile, w_scan_diff;
  logic [3:0] w_scan_attr;
  logic [2:0] w_scan_row;
  logic [12:0] w_scan_addr;
  logic       w_scan_hit;

  assign w_scan_y    = r_oam[{r_dot[5:0], 2'b00}];
  assign w_scan_x    = r_oam[{r_dot[5:0], 2'b01}];
  assign w_scan_tile = r_oam[{r_dot[5:0], 2'b10}];
  assign w_scan_attr = r_oam[{r_dot[5:0], 2'b11}][7:4];
  assign w_scan_diff = r_ly - w_scan_y + 8'd16;
  assign w_scan_row  = w_scan_attr[2] ? ~w_scan_diff[2:0] : w_scan_diff[2:0];
  assign w_scan_addr = {1'b0, w_scan_tile, w_scan_row, 1'b0};
  assign w_scan_hit  = (r_state == StOamScan) && r_lcdc[1] && (w_scan_diff < 8'd8) &&
                       (r_spr_cnt < 4'd10);

  always_ff @(posedge clk) begin
    if (w_scan_hit) begin
      r_spr_lo[r_spr_cnt]    <= r_vram[w_scan_addr];
      r_spr_hi[r_spr_cnt]    <= r_vram[w_scan_addr | 13'd1];
      r_spr_x[r_spr_cnt]     <= w_scan_x;
      r_spr_flags[r_spr_cnt] <= {w_scan_attr[3], w_scan_attr[1], w_scan_attr[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_dot     <= '0;
      r_ly      <= '0;
      r_scy_l   <= '0;
      r_scx_l   <= '0;
      r_wy_l    <= '0;
      r_wx_l    <= '0;
      r_spr_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_dot   <= w_dot_d;
      r_ly    <= w_ly_d;
      if (w_line_start) begin
        r_scy_l   <= r_scy;
        r_scx_l   <= r_scx;
        r_wy_l    <= r_wy;
        r_wx_l    <= r_wx;
        r_spr_cnt <= '0;
      end else if (w_scan_hit) begin
        r_spr_cnt <= r_spr_cnt + 4'd1;
      end
    end
  end

  // Background / window pixel for column w_x of line r_ly.
  logic [7:0]  w_x, w_x7, w_bx, w_by, w_tx, w_ty, w_tile_idx, w_lo, w_hi;
  logic [12:0] w_map_addr, w_tile_addr;
  logic [2:0]  w_bit;
  logic        w_win;
  logic [1:0]  w_bg_col;

  assign w_x  = r_dot - 8'd40;
  assign w_x7 = w_x + 8'd7;
  assign w_bx = w_x + r_scx_l;
  assign w_by = r_ly + r_scy_l;
  assign w_win = r_lcdc[5] && (r_ly >= r_wy_l) && (w_x7 >= r_wx_l);
  assign w_tx = w_win ? (w_x7 - r_wx_l) : w_bx;
  assign w_ty = w_win ? (r_ly - r_wy_l) : w_by;
  assign w_map_addr = {2'b11, (w_win ? r_lcdc[6] : r_lcdc[3]), w_ty[7:3], w_tx[7:3]};
  assign w_tile_idx = r_vram[w_map_addr];
  // Signed mode: index 0..127 lands at 0x1000+, 128..255 wraps down to 0x0800+.
  assign w_tile_addr = {~r_lcdc[4] & ~w_tile_idx[7], w_tile_idx, w_ty[2:0], 1'b0};
  assign w_lo  = r_vram[w_tile_addr];
  assign w_hi  = r_vram[w_tile_addr | 13'd1];
  assign w_bit = ~w_tx[2:0];
  assign w_bg_col = (!w_win && !r_lcdc[0]) ? 2'd0 : {w_hi[w_bit], w_lo[w_bit]};

  logic       w_spr_found, w_spr_pal, w_spr_prio;
  logic [1:0] w_spr_col, w_c;
  logic [7:0] w_col;
  logic [2:0] w_sbit;

  always_comb begin
    w_spr_found = 1'b0;
    w_spr_pal   = 1'b0;
    w_spr_prio  = 1'b0;
    w_spr_col   = 2'd0;
    w_col       = '0;
    w_sbit      = '0;
    w_c         = '0;
    for (int i = 0; i < 10; i++) begin
      w_col  = w_x - r_spr_x[i] + 8'd8;
      w_sbit = r_spr_flags[i][1] ? w_col[2:0] : ~w_col[2:0];
      w_c    = {r_spr_hi[i][w_sbit], r_spr_lo[i][w_sbit]};
      if (!w_spr_found && r_lcdc[1] && (4'(i) < r_spr_cnt) && (w_col < 8'd8) && (w_c != 2'd0))
      begin
        w_spr_found = 1'b1;
        w_spr_col   = w_c;
        w_spr_pal   = r_spr_flags[i][0];
        w_spr_prio  = r_spr_flags[i][2];
      end
    end
  end

  logic       w_use_spr;
  logic [7:0] w_pal;
  logic [1:0] w_color, w_shade;

  assign w_use_spr = w_spr_found && !(w_spr_prio && (w_bg_col != 2'd0));
  assign w_pal     = w_use_spr ? (w_spr_pal ? r_obp1 : r_obp0) : r_bgp;
  assign w_color   = w_use_spr ? w_spr_col : w_bg_col;

  always_comb begin
    w_shade = w_pal[1:0];
    unique case (w_color)
      2'd0: w_shade = w_pal[1:0];
      2'd1: w_shade = w_pal[3:2];
      2'd2: w_shade = w_pal[5:4];
      2'd3: w_shade = w_pal[7:6];
      default: w_shade = w_pal[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out        <= '0;
      r_lcd_x           <= '0;
      r_lcd_y           <= '0;
      r_lcd_pix         <= '0;
      r_lcd_we          <= 1'b0;
      r_render_complete <= 1'b0;
    end else begin
      if (re) r_data_out <= w_rd_data;
      r_lcd_we <= w_lcd_on && (r_state == StDraw);
      if (w_lcd_on && r_state == StDraw) begin
        r_lcd_x   <= w_x;
        r_lcd_y   <= r_ly;
        r_lcd_pix <= w_shade;
      end
      r_render_complete <= w_lcd_on && (r_state == StVBlank) && (r_ly == 8'd144) &&
                           (r_dot == 8'd0);
    end
  end

  // Frame counter, visible in waveforms when debugging.
  if (DEBUG_OUT) begin : g_debug
    logic [15:0] r_frame_cnt;
    always_ff @(posedge clk) begin
      if (!reset) r_frame_cnt <= '0;
      else if (r_render_complete) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign data_out        = r_data_out;
  assign lcd_x           = r_lcd_x;
  assign lcd_y           = r_lcd_y;
  assign lcd_pix         = r_lcd_pix;
  assign lcd_we          = r_lcd_we;
  assign render_complete = r_render_complete;

endmodule

// File: tb/tb_whizgraphics.sv
// Directed bench for whizgraphics: register vector table plus scene-rendering sequences.
module tb_whizgraphics;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  data_out, lcd_x, lcd_y;
  logic [1:0]  lcd_pix;
  logic        lcd_we, render_complete;

  always #5 clk = ~clk;

  whizgraphics #(.DEBUG_OUT(1'b0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out), .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_pix(lcd_pix),
    .lcd_we(lcd_we), .render_complete(render_complete)
  );

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
  } bus_t;

  typedef struct {
    int x;
    int y;
    int exp;
  } pix_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rc_cnt = 0;
  int rc_t0 = 0;
  int rc_t1 = 0;
  int we_seen = 0;
  logic [1:0] fb [144][160];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lcd_we && lcd_x < 8'd160 && lcd_y < 8'd144) fb[lcd_y][lcd_x] = lcd_pix;
    if (lcd_we) we_seen++;
    if (render_complete) begin
      if (rc_cnt == 0) rc_t0 = cyc;
      else if (rc_cnt == 1) rc_t1 = cyc;
      rc_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = data_out;
  endtask

  task automatic wait_pix(input int x, input int y, input int budget, output bit ok,
                          output int pix);
    ok = 1'b0;
    pix = -1;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (lcd_we && lcd_x == x[7:0] && lcd_y == y[7:0]) begin
        ok = 1'b1;
        pix = int'(lcd_pix);
      end
    end
    @(negedge clk);
  endtask

  function automatic bus_t bv(bit w, logic [15:0] a, logic [7:0] d);
    bus_t b;
    b.wr = w; b.a = a; b.d = d;
    return b;
  endfunction

  function automatic pix_t pv(int x, int y, int e);
    pix_t p;
    p.x = x; p.y = y; p.exp = e;
    return p;
  endfunction

  task automatic check_pixels(input string tag, input pix_t q[$]);
    foreach (q[i]) check($sformatf("%s pix(%0d,%0d)", tag, q[i].x, q[i].y),
                         int'(fb[q[i].y][q[i].x]), q[i].exp);
  endtask

  bus_t regv[$];
  pix_t pq[$];
  logic [7:0] rdata;
  bit ok;
  int pix, n0, rc0, t_start;
  int scx_exp [9] = '{3, 3, 3, 3, 0, 0, 0, 0, 0};
  int grad_exp [8] = '{3, 3, 2, 2, 1, 1, 0, 0};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset lcd_we", int'(lcd_we), 0);
    check("reset render_complete", int'(render_complete), 0);
    check("reset lcd_x", int'(lcd_x), 0);
    check("reset lcd_y", int'(lcd_y), 0);
    check("reset lcd_pix", int'(lcd_pix), 0);

    regv.push_back(bv(0, 16'hFF47, 8'hE4));
    regv.push_back(bv(0, 16'hFF48, 8'hE4));
    regv.push_back(bv(0, 16'hFF49, 8'hE4));
    regv.push_back(bv(0, 16'hFF44, 8'h00));
    regv.push_back(bv(0, 16'hFF40, 8'h00));
    regv.push_back(bv(0, 16'hFF4B, 8'h00));
    regv.push_back(bv(0, 16'hFF41, 8'hFF));
    regv.push_back(bv(0, 16'h0123, 8'hFF));
    regv.push_back(bv(0, 16'hFEA0, 8'hFF));
    regv.push_back(bv(1, 16'hFF43, 8'h5A));
    regv.push_back(bv(0, 16'hFF43, 8'h5A));
    regv.push_back(bv(1, 16'h8010, 8'hA5));
    regv.push_back(bv(0, 16'h8010, 8'hA5));
    regv.push_back(bv(1, 16'hFE03, 8'h3C));
    regv.push_back(bv(0, 16'hFE03, 8'h3C));
    regv.push_back(bv(1, 16'hFF44, 8'h77));
    regv.push_back(bv(0, 16'hFF44, 8'h00));
    regv.push_back(bv(1, 16'hFF4A, 8'h21));
    regv.push_back(bv(0, 16'hFF4A, 8'h21));
    regv.push_back(bv(1, 16'hFF4A, 8'h00));
    regv.push_back(bv(1, 16'hFF43, 8'h00));
    regv.push_back(bv(0, 16'hFF43, 8'h00));
    foreach (regv[i]) begin
      if (regv[i].wr) begin
        wr(regv[i].a, regv[i].d);
      end else begin
        rd(regv[i].a, rdata);
        check($sformatf("read %h", regv[i].a), int'(rdata), int'(regv[i].d));
      end
    end

    repeat (50) @(negedge clk);
    check("lcd_we idle while disabled", we_seen, 0);

    // Scene: tile0 blank, tile1 rows 0-3 F0/F0 and rows 4-7 0F/0F, map[0]=1.
    for (int i = 0; i < 1024; i++) wr(16'h9800 + 16'(i), 8'h00);
    for (int i = 0; i < 16; i++) wr(16'h8000 + 16'(i), 8'h00);
    for (int i = 0; i < 16; i++) wr(16'h8010 + 16'(i), (i < 8) ? 8'hF0 : 8'h0F);
    for (int i = 0; i < 160; i++) wr(16'hFE00 + 16'(i), 8'h00);
    wr(16'h9800, 8'h01);

    wr(16'hFF40, 8'h91);
    t_start = cyc;
    for (int k = 0; k < 62000 && rc_cnt < 2; k++) @(negedge clk);
    @(negedge clk);
    check("two frames completed", rc_cnt, 2);
    check("first render_complete latency", rc_t0 - t_start, 28801);
    check("render_complete period", rc_t1 - rc_t0, 30800);
    pq = {};
    pq.push_back(pv(0, 0, 3));   pq.push_back(pv(3, 0, 3));
    pq.push_back(pv(4, 0, 0));   pq.push_back(pv(7, 0, 0));
    pq.push_back(pv(0, 3, 3));   pq.push_back(pv(0, 4, 0));
    pq.push_back(pv(3, 4, 0));   pq.push_back(pv(4, 4, 3));
    pq.push_back(pv(7, 7, 3));   pq.push_back(pv(8, 0, 0));
    pq.push_back(pv(0, 8, 0));   pq.push_back(pv(159, 143, 0));
    check_pixels("frame", pq);

    // Disable mid-frame at LY=50.
    wait_pix(10, 50, 15000, ok, pix);
    check("reached LY 50", int'(ok), 1);
    wr(16'hFF40, 8'h11);
    check("lcd_we after disable", int'(lcd_we), 0);
    rd(16'hFF44, rdata);
    check("LY after disable", int'(rdata), 0);
    n0 = we_seen;
    rc0 = rc_cnt;
    repeat (400) @(negedge clk);
    check("no pixels while off", we_seen - n0, 0);
    check("no render_complete while off", rc_cnt - rc0, 0);
    wr(16'hFF40, 8'h91);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (lcd_we) ok = 1'b1;
    end
    check("re-enable draws", int'(ok), 1);
    check("re-enable first x", int'(lcd_x), 0);
    check("re-enable first y", int'(lcd_y), 0);
    wr(16'hFF40, 8'h00);

    // Horizontal scroll: pixel (0,0) per SCX value.
    for (int s = 0; s < 9; s++) begin
      wr(16'hFF43, 8'(s));
      wr(16'hFF40, 8'h91);
      wait_pix(0, 0, 300, ok, pix);
      check($sformatf("scx=%0d seen", s), int'(ok), 1);
      check($sformatf("scx=%0d pix(0,0)", s), pix, scx_exp[s]);
      wr(16'hFF40, 8'h00);
    end
    wr(16'hFF43, 8'h00);

    // Gradient tile through an inverted palette, then the window over it.
    for (int i = 0; i < 16; i++) wr(16'h8020 + 16'(i), (i % 2 == 0) ? 8'h33 : 8'h0F);
    wr(16'h9800, 8'h02);
    wr(16'hFF47, 8'h1B);
    wr(16'hFF40, 8'h91);
    wait_pix(7, 0, 300, ok, pix);
    check("gradient seen", int'(ok), 1);
    pq = {};
    for (int x = 0; x < 8; x++) pq.push_back(pv(x, 0, grad_exp[x]));
    check_pixels("gradient", pq);
    wr(16'hFF40, 8'h00);
    wr(16'hFF4B, 8'd87);
    wr(16'hFF40, 8'hB1);
    wait_pix(87, 0, 400, ok, pix);
    check("window seen", int'(ok), 1);
    pq = {};
    pq.push_back(pv(79, 0, 3)); pq.push_back(pv(80, 0, 3));
    pq.push_back(pv(82, 0, 2)); pq.push_back(pv(84, 0, 1));
    pq.push_back(pv(86, 0, 0));
    check_pixels("window", pq);
    wr(16'hFF40, 8'h00);
    wr(16'hFF47, 8'hE4);
    wr(16'h9800, 8'h00);

    // Sprite 0 at Y=26 X=18 using tile1, blank background.
    wr(16'hFE00, 8'd26);
    wr(16'hFE01, 8'd18);
    wr(16'hFE02, 8'd1);
    wr(16'hFE03, 8'h00);
    wr(16'hFF40, 8'h93);
    wait_pix(159, 14, 4000, ok, pix);
    check("sprite frame seen", int'(ok), 1);
    pq = {};
    pq.push_back(pv(10, 10, 3)); pq.push_back(pv(13, 13, 3));
    pq.push_back(pv(13, 10, 3)); pq.push_back(pv(9, 10, 0));
    pq.push_back(pv(14, 10, 0)); pq.push_back(pv(10, 9, 0));
    pq.push_back(pv(10, 14, 0)); pq.push_back(pv(14, 14, 3));
    check_pixels("sprite", pq);
    wr(16'hFF40, 8'h00);
    wr(16'hFE03, 8'h20);
    wr(16'hFF40, 8'h93);
    wait_pix(159, 14, 4000, ok, pix);
    check("xflip frame seen", int'(ok), 1);
    pq = {};
    pq.push_back(pv(14, 10, 3)); pq.push_back(pv(17, 13, 3));
    pq.push_back(pv(13, 10, 0)); pq.push_back(pv(10, 10, 0));
    check_pixels("xflip", pq);
    wr(16'hFF40, 8'h00);
    wr(16'hFE03, 8'h30);
    wr(16'hFF49, 8'h80);
    wr(16'hFF40, 8'h93);
    wait_pix(159, 14, 4000, ok, pix);
    check("obp1 frame seen", int'(ok), 1);
    pq = {};
    pq.push_back(pv(14, 10, 2)); pq.push_back(pv(10, 10, 0));
    check_pixels("obp1", pq);
    wr(16'hFF40, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
